// File: rtl/pulse_gen_pkg.sv
// Shared FSM state encodings and phase-selection helper for pulse_gen.
package pulse_gen_pkg;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [ST_W-1:0] ST_DELAY   = 2'd1;
    localparam logic [ST_W-1:0] ST_ACTIVE  = 2'd2;
    localparam logic [ST_W-1:0] ST_HOLDOFF = 2'd3;

    // First phase that actually has cycles to spend; zero-length phases are skipped.
    // Returns IDLE when every remaining phase is empty.
    function automatic logic [ST_W-1:0] first_phase(
        input logic delay_nz,
        input logic width_nz,
        input logic holdoff_nz
    );
        if (delay_nz)        return ST_DELAY;
        else if (width_nz)   return ST_ACTIVE;
        else if (holdoff_nz) return ST_HOLDOFF;
        else                 return ST_IDLE;
    endfunction

endpackage

// File: rtl/pulse_gen.sv
// Programmable one-shot pulse generator: trigger -> delay -> active pulse -> hold-off.
// One shared down-counter serves all three phases; configuration is captured on
// trigger acceptance so later input changes do not disturb a sequence in flight.
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       activetype,
    input  logic             trigger,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] holdoff,
    input  logic             retrig_en,
    output logic             out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [ST_W-1:0]  state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [CNT_W-1:0] delay_q,   delay_d;
    logic [CNT_W-1:0] width_q,   width_d;
    logic [CNT_W-1:0] holdoff_q, holdoff_d;
    logic             done_q,    done_d;

    logic trig_act;
    logic accept;
    logic out_p;

    // Trigger is level-sampled; edge qualification is done upstream.
    assign trig_act = (trigger == activetype[0]);
    assign accept   = (state_q == ST_IDLE) && trig_act;

    // Next-state, counter and config-capture logic.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        delay_d   = delay_q;
        width_d   = width_q;
        holdoff_d = holdoff_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (trig_act) begin
                    delay_d   = delay;
                    width_d   = width;
                    holdoff_d = holdoff;
                    state_d   = first_phase(delay != '0, width != '0, holdoff != '0);
                end
            end
            ST_DELAY: begin
                if (cnt_q == '0) state_d = first_phase(1'b0, width_q != '0, holdoff_q != '0);
                else             cnt_d   = cnt_q - ONE;
            end
            ST_ACTIVE: begin
                // Retrigger reload wins over the end-of-width exit.
                if (retrig_en && trig_act) cnt_d   = width_q - ONE;
                else if (cnt_q == '0)      state_d = first_phase(1'b0, 1'b0, holdoff_q != '0);
                else                       cnt_d   = cnt_q - ONE;
            end
            ST_HOLDOFF: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - ONE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Phase entry: load the counter for the new phase from the captured config.
        // Landing in IDLE (including an all-zero sequence) completes the run.
        if (accept || (state_d != state_q)) begin
            case (state_d)
                ST_DELAY:   cnt_d = delay_d - ONE;
                ST_ACTIVE:  cnt_d = width_d - ONE;
                ST_HOLDOFF: cnt_d = holdoff_d - ONE;
                default:    cnt_d = '0;
            endcase
            done_d = (state_d == ST_IDLE);
        end
    end

    // State registers; reset drops any sequence in flight without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            delay_q   <= '0;
            width_q   <= '0;
            holdoff_q <= '0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            delay_q   <= delay_d;
            width_q   <= width_d;
            holdoff_q <= holdoff_d;
            done_q    <= done_d;
        end
    end

    // Output polarity follows activetype combinationally, so it is valid during reset too.
    assign out_p = (state_q == ST_ACTIVE);
    assign out   = activetype[1] ? out_p : ~out_p;
    assign busy  = (state_q != ST_IDLE);
    assign done  = done_q;

endmodule
